instr_sequencer: RTL

//   Multi-cycle sequencer for the KGP-RISC datapath. Steps each instruction through

---
 rtl/instr_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the KGP-RISC datapath.
// Issues PC/IR/memory/register-file strobes, and traps memory timeouts and illegal opcodes.
module instr_sequencer #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ir_load,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_write_en,
    output logic             halted,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [2:0] C_WB   = 3'd0;  // ALU ops, move, bl
    localparam logic [2:0] C_LW   = 3'd1;
    localparam logic [2:0] C_SW   = 3'd2;
    localparam logic [2:0] C_BR   = 3'd3;  // branches other than bl, beq
    localparam logic [2:0] C_NOP  = 3'd4;
    localparam logic [2:0] C_HALT = 3'd5;
    localparam logic [2:0] C_ILL  = 3'd6;

    logic [2:0]       r_state;
    logic [2:0]       r_cls;
    logic [31:0]      r_wait;
    logic             r_illegal;
    logic             r_bus_err;
    logic [CNT_W-1:0] r_retired;

    logic [2:0] w_cls;
    logic [2:0] w_next;
    logic       w_req;
    logic       w_we;
    logic       w_ir;
    logic       w_pc;
    logic       w_rwe;
    logic       w_timeout;

    function automatic logic [2:0] f_classify(input logic [5:0] op);
        logic [2:0] cls;
        cls = C_ILL;
        if (op <= 6'd5)                        cls = C_WB;
        else if (op == 6'd6)                   cls = C_LW;
        else if (op == 6'd7)                   cls = C_SW;
        else if (op >= 6'd8 && op <= 6'd14)    cls = C_BR;
        else if (op == 6'd15 || op == 6'd16)   cls = C_WB;
        else if (op == 6'd17)                  cls = C_BR;
        else if (op == 6'd62)                  cls = C_NOP;
        else if (op == 6'd63)                  cls = C_HALT;
        return cls;
    endfunction

    assign w_cls = f_classify(opcode);

    assign w_req     = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_we      = (r_state == S_MEM) && (r_cls == C_SW);
    assign w_ir      = (r_state == S_FETCH) && mem_ready;
    assign w_rwe     = (r_state == S_WB);
    assign w_timeout = (MEM_TIMEOUT != 0) && w_req && !mem_ready
                       && (r_wait == 32'(MEM_TIMEOUT - 1));

    // sw retires in the MEM cycle that completes it, so its pc_en follows mem_ready directly.
    assign w_pc = ((r_state == S_DECODE) && (w_cls == C_NOP))
               || ((r_state == S_EXEC) && (r_cls == C_BR))
               || ((r_state == S_MEM) && (r_cls == C_SW) && mem_ready)
               || (r_state == S_WB);

    // NOTE: w_next gets a default before the case so no path through this block infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_timeout)      w_next = S_ERROR;
                else if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (w_cls)
                    C_HALT:  w_next = S_HALT;
                    C_NOP:   w_next = S_FETCH;
                    C_ILL:   w_next = S_ERROR;
                    default: w_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (r_cls)
                    C_LW, C_SW: w_next = S_MEM;
                    C_BR:       w_next = S_FETCH;
                    default:    w_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (w_timeout)      w_next = S_ERROR;
                else if (mem_ready) w_next = (r_cls == C_LW) ? S_WB : S_FETCH;
            end
            S_WB:    w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_ERROR;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_cls     <= C_NOP;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_cls <= w_cls;
                if (w_cls == C_ILL) r_illegal <= 1'b1;
            end
            // Wait count covers one request only: it restarts on completion or any state change.
            if (w_req && !mem_ready && (w_next == r_state)) r_wait <= r_wait + 32'd1;
            else                                            r_wait <= '0;
            if (w_timeout) r_bus_err <= 1'b1;
            if (w_pc)      r_retired <= r_retired + 1'b1;
        end
    end

    assign pc_en        = w_pc  & ~reset;
    assign ir_load      = w_ir  & ~reset;
    assign mem_req      = w_req & ~reset;
    assign mem_we       = w_we  & ~reset;
    assign reg_write_en = w_rwe & ~reset;
    assign halted       = (r_state == S_HALT) || (r_state == S_ERROR);
    assign illegal_op   = r_illegal;
    assign bus_err      = r_bus_err;
    assign state        = r_state;
    assign retired      = r_retired;

endmodule
